// File: rtl/intr_pending_ctrl_if.sv
// CPU-side bundle for intr_pending_ctrl: raw lines, mask/ack/eoi strobes and the register view.
// Mode-register ports exist only when INTR_LEVEL_MODE_EN is defined.
interface intr_pending_ctrl_if;
    logic [7:0] irq_in;
    logic       mask_we;
    logic [7:0] mask_wdata;
    logic       ack;
    logic [2:0] ack_vec;
    logic       eoi;
    logic [7:0] intr_out;
    logic [7:0] pending;
    logic [7:0] mask;
    logic [7:0] in_service;
    logic       spurious;
`ifdef INTR_LEVEL_MODE_EN
    logic       mode_we;
    logic [7:0] mode_wdata;

    modport master (
        output irq_in, mask_we, mask_wdata, ack, ack_vec, eoi, mode_we, mode_wdata,
        input  intr_out, pending, mask, in_service, spurious
    );
    modport slave (
        input  irq_in, mask_we, mask_wdata, ack, ack_vec, eoi, mode_we, mode_wdata,
        output intr_out, pending, mask, in_service, spurious
    );
`else
    modport master (
        output irq_in, mask_we, mask_wdata, ack, ack_vec, eoi,
        input  intr_out, pending, mask, in_service, spurious
    );
    modport slave (
        input  irq_in, mask_we, mask_wdata, ack, ack_vec, eoi,
        output intr_out, pending, mask, in_service, spurious
    );
`endif
endinterface

// File: rtl/intr_pending_ctrl.sv
// Interrupt capture stage: synchronise, edge-detect, pending/mask/in-service with priority nesting.
// Define INTR_LEVEL_MODE_EN to add a per-line level-trigger mode register.
module intr_pending_ctrl #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  MASK_RESET  = 8'h00
) (
    input logic               clk,
    input logic               rst,
    intr_pending_ctrl_if.slave bus
);

    logic [7:0] sync_q [SYNC_STAGES];
    logic [7:0] sync_d [SYNC_STAGES];
    logic [7:0] irq_d_q, irq_d_d;
    logic [7:0] pending_q, pending_d;
    logic [7:0] mask_q, mask_d;
    logic [7:0] in_service_q, in_service_d;
    logic       spurious_q, spurious_d;

    logic [7:0] irq_s, rise, set_vec;
    logic [7:0] allow, hi_oh, ack_oh, intr_out;
    logic       ack_valid;

`ifdef INTR_LEVEL_MODE_EN
    logic [7:0] mode_q, mode_d;
`endif

    assign irq_s = sync_q[SYNC_STAGES-1];
    assign rise  = irq_s & ~irq_d_q;

    always_comb begin
        sync_d[0] = bus.irq_in;
        for (int s = 1; s < int'(SYNC_STAGES); s++) begin
            sync_d[s] = sync_q[s-1];
        end
    end

    // allow[i]: nothing at priority i or above is in service; hi_oh: highest in-service bit
    always_comb begin
        allow = '0;
        hi_oh = '0;
        for (int i = 0; i < 8; i++) begin
            allow[i] = ~|(in_service_q >> i);
            hi_oh[i] = in_service_q[i] & ~|(in_service_q >> (i + 1));
        end
    end

    assign intr_out  = pending_q & mask_q & allow;
    assign ack_oh    = 8'h01 << bus.ack_vec;
    assign ack_valid = bus.ack & |(intr_out & ack_oh);

`ifdef INTR_LEVEL_MODE_EN
    assign set_vec = rise | (irq_s & mode_q);
    assign mode_d  = bus.mode_we ? bus.mode_wdata : mode_q;
`else
    assign set_vec = rise;
`endif

    always_comb begin
        irq_d_d      = irq_s;
        mask_d       = bus.mask_we ? bus.mask_wdata : mask_q;
        pending_d    = (pending_q & ~(ack_valid ? ack_oh : 8'h00)) | set_vec;
        in_service_d = in_service_q;
        // eoi retires the pre-edge highest bit before a same-cycle ack adds its own
        if (bus.eoi) begin
            in_service_d = in_service_d & ~hi_oh;
        end
        if (ack_valid) begin
            in_service_d = in_service_d | ack_oh;
        end
        spurious_d = bus.ack & ~ack_valid;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < int'(SYNC_STAGES); s++) begin
                sync_q[s] <= '0;
            end
            irq_d_q      <= '0;
            pending_q    <= '0;
            mask_q       <= MASK_RESET;
            in_service_q <= '0;
            spurious_q   <= 1'b0;
        end else begin
            sync_q       <= sync_d;
            irq_d_q      <= irq_d_d;
            pending_q    <= pending_d;
            mask_q       <= mask_d;
            in_service_q <= in_service_d;
            spurious_q   <= spurious_d;
        end
    end

`ifdef INTR_LEVEL_MODE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q <= '0;
        end else begin
            mode_q <= mode_d;
        end
    end
`endif

    assign bus.intr_out   = intr_out;
    assign bus.pending    = pending_q;
    assign bus.mask       = mask_q;
    assign bus.in_service = in_service_q;
    assign bus.spurious   = spurious_q;

endmodule
